// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for the five-stage LEGv8 pipeline.
// Optional stall/flush event counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int LOAD_USE_STALLS = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ifid_instruction,
   input  logic        idex_memread,
   input  logic [4:0]  idex_write_reg,
   input  logic        mem_pc_src,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_flush,
   output logic        state,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   generate
      if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 3) begin : g_bad_cfg
         $error("hazard_ctrl: LOAD_USE_STALLS must be 1..3");
      end
   endgenerate

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_flush;
   } ctl_t;

   localparam ctl_t CTL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctl_t CTL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam ctl_t CTL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

   state_t     state_q, state_nxt;
   logic [1:0] cnt_q, cnt_nxt;
   ctl_t       ctl;

   // Source register usage decode
   logic [4:0] rn, rm, rt;
   logic       rm_used, rt_used, hazard;
   logic       unused_bits;

   assign rn      = ifid_instruction[9:5];
   assign rm      = ifid_instruction[20:16];
   assign rt      = ifid_instruction[4:0];
   assign rm_used = (ifid_instruction[28:25] == 4'b0101);
   assign rt_used = (ifid_instruction[31:21] == 11'h7C0) || (ifid_instruction[31:24] == 8'hB4);
   assign unused_bits = ^ifid_instruction[15:10];

   assign hazard = idex_memread && (idex_write_reg != 5'd31) &&
                   ((idex_write_reg == rn) ||
                    (rm_used && idex_write_reg == rm) ||
                    (rt_used && idex_write_reg == rt));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      ctl       = CTL_NORMAL;
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      if (reset) begin
         ctl       = CTL_RESET;
         state_nxt = RUN;
         cnt_nxt   = 2'd0;
      end else if (mem_pc_src) begin
         ctl       = CTL_FLUSH;
         state_nxt = RUN;
         cnt_nxt   = 2'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (hazard) begin
                  ctl = CTL_STALL;
                  if (LOAD_USE_STALLS > 1) begin
                     state_nxt = STALL;
                     cnt_nxt   = CNT_INIT;
                  end
               end
            end
            STALL: begin
               // IF/ID is frozen here, so the hazard input is not re-evaluated
               ctl = CTL_STALL;
               if (cnt_q <= 2'd1) begin
                  state_nxt = RUN;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt = cnt_q - 2'd1;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = 2'd0;
            end
         endcase
      end
   end

   assign pc_write    = ctl.pc_write;
   assign ifid_write  = ctl.ifid_write;
   assign ifid_flush  = ctl.ifid_flush;
   assign idex_bubble = ctl.idex_bubble;
   assign exmem_flush = ctl.exmem_flush;
   assign state       = (state_q == STALL);

`ifdef HAZARD_PERF_CNT_EN
   logic        stall_act;
   logic [31:0] stall_q, flush_q;

   // Stall outputs are the only non-reset condition with a bubble but no flush
   assign stall_act = ctl.idex_bubble && !ctl.ifid_flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (stall_act && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
         if (mem_pc_src && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = 32'h0;
   assign flush_events = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 3 stall cycles) driven in lockstep.
module tb_hazard_ctrl;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ins;
   logic        mr;
   logic [4:0]  wr;
   logic        psrc;

   logic        pw1, iw1, if1, bb1, ef1, st1;
   logic        pw3, iw3, if3, bb3, ef3, st3;
   logic [31:0] sc1, fe1, sc3, fe3;

   always #5 clock = ~clock;

   hazard_ctrl #(.LOAD_USE_STALLS(1)) u_n1 (
      .clock(clock), .reset(reset), .ifid_instruction(ins), .idex_memread(mr),
      .idex_write_reg(wr), .mem_pc_src(psrc), .pc_write(pw1), .ifid_write(iw1),
      .ifid_flush(if1), .idex_bubble(bb1), .exmem_flush(ef1), .state(st1),
      .stall_cycles(sc1), .flush_events(fe1));

   hazard_ctrl #(.LOAD_USE_STALLS(3)) u_n3 (
      .clock(clock), .reset(reset), .ifid_instruction(ins), .idex_memread(mr),
      .idex_write_reg(wr), .mem_pc_src(psrc), .pc_write(pw3), .ifid_write(iw3),
      .ifid_flush(if3), .idex_bubble(bb3), .exmem_flush(ef3), .state(st3),
      .stall_cycles(sc3), .flush_events(fe3));

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {state, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
   typedef struct {
      logic [5:0]  c [2];
      logic [31:0] s [2];
      logic [31:0] f [2];
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   int          m_rem [2];
   logic [31:0] m_sc  [2];
   logic [31:0] m_fe  [2];
   int          m_n   [2] = '{1, 3};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit hz(input logic [31:0] i, input logic m, input logic [4:0] w);
      bit r_fmt, st_cb;
      r_fmt = (i[28:25] == 4'b0101);
      st_cb = (i[31:21] == 11'h7C0) || (i[31:24] == 8'hB4);
      if (!m || w == 5'd31) return 1'b0;
      return (w == i[9:5]) || (r_fmt && w == i[20:16]) || (st_cb && w == i[4:0]);
   endfunction

   task automatic step(input logic [31:0] i, input logic m, input logic [4:0] w,
                       input logic p, input logic r);
      exp_t e, g;
      @(negedge clock);
      ins = i; mr = m; wr = w; psrc = p; reset = r;
      for (int k = 0; k < 2; k++) begin
         logic st;
         st = (m_rem[k] > 0);
         e.s[k] = PERF ? m_sc[k] : 32'h0;
         e.f[k] = PERF ? m_fe[k] : 32'h0;
         if (r)                   e.c[k] = {st, 5'b00111};
         else if (p)              e.c[k] = {st, 5'b11111};
         else if (st || hz(i,m,w)) e.c[k] = {st, 5'b00010};
         else                     e.c[k] = {st, 5'b11000};
         // model state advance at the coming rising edge
         if (r) begin
            m_rem[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
         end else if (p) begin
            m_rem[k] = 0;
            if (m_fe[k] != 32'hFFFF_FFFF) m_fe[k]++;
         end else if (st || hz(i,m,w)) begin
            m_rem[k] = st ? m_rem[k] - 1 : m_n[k] - 1;
            if (m_sc[k] != 32'hFFFF_FFFF) m_sc[k]++;
         end
      end
      sb.push_back(e);
      #2;
      g = sb.pop_front();
      chk("ctl_n1", {26'd0, st1, pw1, iw1, if1, bb1, ef1}, {26'd0, g.c[0]});
      chk("ctl_n3", {26'd0, st3, pw3, iw3, if3, bb3, ef3}, {26'd0, g.c[1]});
      chk("stall_n1", sc1, g.s[0]);
      chk("flush_n1", fe1, g.f[0]);
      chk("stall_n3", sc3, g.s[1]);
      chk("flush_n3", fe3, g.f[1]);
   endtask

   localparam logic [31:0] ADD_X2_X1_X3  = 32'h8B03_0022;
   localparam logic [31:0] ADD_X2_X31_X3 = 32'h8B03_03E2;
   localparam logic [31:0] ADD_X2_X1_X5  = 32'h8B05_0022;
   localparam logic [31:0] ADDI_RM5_RD5  = 32'h9105_0025;
   localparam logic [31:0] STUR_X5       = 32'hF800_0025;
   localparam logic [31:0] CBZ_X5        = 32'hB400_0005;

   logic [31:0] pool [6];

   initial begin
      pool = '{ADD_X2_X1_X3, ADD_X2_X31_X3, ADD_X2_X1_X5, ADDI_RM5_RD5, STUR_X5, CBZ_X5};
      reset = 1'b1; ins = 32'h0; mr = 1'b0; wr = 5'd0; psrc = 1'b0;
      @(posedge clock);
      for (int k = 0; k < 2; k++) begin m_rem[k] = 0; m_sc[k] = 0; m_fe[k] = 0; end

      step(32'h0, 0, 0, 0, 1);
      step(32'h0, 0, 0, 0, 1);
      // basic load-use on Rn
      step(ADD_X2_X1_X3, 1, 5'd1, 0, 0);
      repeat (3) step(ADD_X2_X1_X3, 0, 5'd1, 0, 0);
      // XZR destination never stalls
      step(ADD_X2_X31_X3, 1, 5'd31, 0, 0);
      // ADDI immediate bits and Rd are not sources
      step(ADDI_RM5_RD5, 1, 5'd5, 0, 0);
      // STUR/CBZ Rt and R-format Rm are sources
      step(STUR_X5, 1, 5'd5, 0, 0);
      repeat (3) step(STUR_X5, 0, 5'd5, 0, 0);
      step(CBZ_X5, 1, 5'd5, 0, 0);
      repeat (3) step(CBZ_X5, 0, 5'd5, 0, 0);
      step(ADD_X2_X1_X5, 1, 5'd5, 0, 0);
      repeat (3) step(ADD_X2_X1_X5, 0, 5'd5, 0, 0);
      // flush in second stall cycle
      step(ADD_X2_X1_X3, 1, 5'd1, 0, 0);
      step(ADD_X2_X1_X3, 0, 5'd1, 1, 0);
      repeat (2) step(ADD_X2_X1_X3, 0, 5'd1, 0, 0);
      // hazard and flush together
      step(ADD_X2_X1_X3, 1, 5'd1, 1, 0);
      step(ADD_X2_X1_X3, 0, 5'd1, 0, 0);
      // reset during stall
      step(ADD_X2_X1_X3, 1, 5'd1, 0, 0);
      step(ADD_X2_X1_X3, 0, 5'd1, 0, 1);
      repeat (2) step(ADD_X2_X1_X3, 0, 5'd1, 0, 0);
      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [4:0] w;
         case ($urandom_range(0, 3))
            0: w = 5'd1;
            1: w = 5'd5;
            2: w = 5'd31;
            default: w = 5'($urandom);
         endcase
         step(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), w,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
